m_mem_initiator: RTL and testbench
==================================

// Module: m_mem_initiator
// PURPOSE
//  M-stage load/store initiator: turns the pipeline's memory op (dm_sel, addr, wdata) into a
//  valid/ready request on the word-wide data-memory bus. It shifts store data into byte lanes and
//  decodes load data with sign or zero extension. It stalls the pipeline until the access completes.
//  It sits between the M-stage pipeline register and the data memory responder (12 KB, word array).
// PARAMETERS
//  ADDR_LIMIT  32'h0000_3000  first illegal byte address; addr >= ADDR_LIMIT raises addr_exc
// PORTS
//  clk          in   1   clock
//  reset        in   1   synchronous, active-high
//  req_valid    in   1   M stage holds a load/store
//  req_we       in   1   1 = store, 0 = load
//  dm_sel       in   3   access size/sign, encoded as in mem_pkg
//  addr         in   32  byte address
//  wdata        in   32  store data, right-aligned
//  pc           in   32  PC of the M-stage instruction, used for trace only
//  stall        out  1   hold the pipeline
//  rdata        out  32  extended load result
//  rdata_valid  out  1   rdata and store completion valid, single-cycle pulse
//  addr_exc     out  1   misaligned or out-of-range access, combinational, no bus traffic
//  bus_req      out  1   request valid
//  bus_we       out  1   request is a write
//  bus_addr     out  32  word-aligned address {addr[31:2],2'b00}
//  bus_be       out  4   byte enables
//  bus_wdata    out  32  lane-shifted store data
//  bus_gnt      in   1   responder accepts request this cycle
//  bus_rvalid   in   1   read data valid
//  bus_rdata    in   32  raw read word
// BEHAVIOUR
//  Reset values: stall=0, rdata=0, rdata_valid=0, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0.
//  FSM states IDLE, REQ, RESP, DONE; reset forces IDLE from any state and drops bus_req immediately.
//  IDLE:
//   - req_valid && !addr_exc: latch request -> REQ.
//   - addr_exc asserts when W has addr[1:0]!=0, when H/HU has addr[0]!=0, or when addr>=ADDR_LIMIT.
//   - addr_exc=1: stay in IDLE, no stall, no bus_req.
//  REQ:
//   - bus_req=1; bus_we/addr/be/wdata stay stable until grant.
//   - bus_gnt && we: go to DONE (write commits at grant).
//   - bus_gnt && !we: go to RESP.
//  RESP:
//   - Wait any number of cycles for bus_rvalid.
//   - On bus_rvalid: register the extended rdata, then go to DONE.
//   - bus_rvalid in any other state is ignored.
//  DONE:
//   - rdata_valid=1 for one cycle, stall=0, then IDLE.
//   - The new req_valid is sampled in the following IDLE cycle.
//  stall = req_valid && !addr_exc && state!=DONE. Minimum latency: store 2 cycles, load 3 cycles.
//  Byte enables:
//   - W: 4'b1111.
//   - H/HU: 4'b0011 << 2*addr[1].
//   - B/BU: 4'b0001 << addr[1:0].
//  Write data is replicated: W = wdata, H = {2{wdata[15:0]}}, B = {4{wdata[7:0]}}.
//  Load data:
//   - Select the lane with addr[1:0] latched in IDLE.
//   - H and B sign-extend; HU and BU zero-extend; W passes through.
//  Undefined dm_sel: treat as W for the bus and return rdata=0.
//  rdata holds its value until the next load completes.
// CONFIGURATION
//  MEM_TRACE_EN defined: on every store grant, $display("%d@%h: *%h <= %h", $time, pc_latched,
//   bus_addr, masked data). In masked data, lanes not enabled by bus_be read as 8'h00.
//  MEM_TRACE_EN undefined: no trace logic and no $display; behaviour is otherwise identical.
// STRUCTURE
//  mem_pkg (shared with the data memory):
//   - DM_W=3'd0, DM_H=3'd1, DM_HU=3'd2, DM_B=3'd3, DM_BU=3'd4.
//   - Width constants; FSM state typedef.
//  One sub-module, m_mem_lane_fmt (combinational): builds be/wdata and extends rdata.
// TESTING
//  - Store W addr=0x10 wdata=0xDEADBEEF, gnt after 2 cycles -> be=1111, bus_addr=0x10, stall 3 cycles, rdata_valid pulse.
//  - Load B addr=0x13, bus_rdata=0x80FF_0000 -> rdata=0xFFFF_FF80. Same access as BU -> 0x0000_0080.
//  - Store H addr=0x22 wdata=0x1234ABCD -> be=1100, bus_wdata=0xABCD_ABCD.
//  - Load W addr=0x06 -> addr_exc=1, bus_req never asserts, stall=0. Load addr=0x3000 -> addr_exc=1.
//  - reset in RESP with load pending -> next cycle IDLE, bus_req=0, stall=0, rdata=0.
//    A late bus_rvalid is then ignored.
//  - Back-to-back: store then load with gnt held high -> exactly two grants, each with one rdata_valid pulse.

Source files
------------

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Definitions shared by the M-stage load/store initiator and the data memory:
// the dm_sel access-size encoding, bus width constants, the initiator FSM state
// type and the alignment helper used for address-exception detection.
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam int XLEN    = 32;
  localparam int BE_W    = XLEN / 8;
  localparam int DMSEL_W = 3;

  // Access size / sign encoding carried by dm_sel
  localparam logic [DMSEL_W-1:0] DM_W  = 3'd0;
  localparam logic [DMSEL_W-1:0] DM_H  = 3'd1;
  localparam logic [DMSEL_W-1:0] DM_HU = 3'd2;
  localparam logic [DMSEL_W-1:0] DM_B  = 3'd3;
  localparam logic [DMSEL_W-1:0] DM_BU = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  // Misalignment for a given access size. Undefined encodings behave as word.
  function automatic logic sel_misaligned(input logic [DMSEL_W-1:0] sel,
                                          input logic [1:0]         lo);
    logic mis;
    case (sel)
      DM_H, DM_HU: mis = lo[0];
      DM_B, DM_BU: mis = 1'b0;
      default:     mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/m_mem_lane_fmt.sv
// -----------------------------------------------------------------------------
// m_mem_lane_fmt
// Purely combinational byte-lane formatter for the data-memory bus.
//  Store side: byte enables and replicated store data from the live request.
//  Load side : lane selection and sign/zero extension of the raw read word,
//              using the size and low address bits captured with the request.
// Ports:
//  wr_sel_i  [2:0]  store/request access size (dm_sel encoding)
//  wr_lo_i   [1:0]  request byte offset
//  wdata_i   [31:0] right-aligned store data
//  be_o      [3:0]  byte enables
//  wdata_o   [31:0] lane-replicated store data
//  rd_sel_i  [2:0]  latched access size for the pending load
//  rd_lo_i   [1:0]  latched byte offset for the pending load
//  rdata_i   [31:0] raw read word from the bus
//  rdata_o   [31:0] extended load result (0 for undefined sizes)
// -----------------------------------------------------------------------------
module m_mem_lane_fmt
  import mem_pkg::*;
(
  input  logic [2:0]  wr_sel_i,
  input  logic [1:0]  wr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [2:0]  rd_sel_i,
  input  logic [1:0]  rd_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] rdata_o
);

  logic [15:0] half_s;
  logic [7:0]  byte_s;

  // Store-side enables and data replication
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    case (wr_sel_i)
      DM_H, DM_HU: begin
        be_o    = 4'b0011 << {wr_lo_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
      end
      DM_B, DM_BU: begin
        be_o    = 4'b0001 << wr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
      end
    endcase
  end

  // Load-side lane pick
  always_comb begin
    half_s = rd_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (rd_lo_i)
      2'd0:    byte_s = rdata_i[7:0];
      2'd1:    byte_s = rdata_i[15:8];
      2'd2:    byte_s = rdata_i[23:16];
      default: byte_s = rdata_i[31:24];
    endcase
  end

  // Load-side extension; undefined sizes return zero
  always_comb begin
    case (rd_sel_i)
      DM_W:    rdata_o = rdata_i;
      DM_H:    rdata_o = {{16{half_s[15]}}, half_s};
      DM_HU:   rdata_o = {16'h0000, half_s};
      DM_B:    rdata_o = {{24{byte_s[7]}}, byte_s};
      DM_BU:   rdata_o = {24'h00_0000, byte_s};
      default: rdata_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/m_mem_initiator.sv
// -----------------------------------------------------------------------------
// m_mem_initiator
// M-stage load/store initiator. Converts the pipeline memory op into a
// valid/ready request on the word-wide data-memory bus, stalls the pipeline
// until the access completes and returns the extended load result.
// Optional build macro: MEM_TRACE_EN (prints one line per store grant).
// Ports:
//  clk, reset            clock, synchronous active-high reset
//  req_valid_i/req_we_i  M stage holds a load/store; 1 = store
//  dm_sel_i [2:0]        access size/sign (mem_pkg encoding)
//  addr_i, wdata_i       byte address, right-aligned store data
//  pc_i                  PC of the M-stage instruction (trace only)
//  stall_o               hold the pipeline
//  rdata_o/rdata_valid_o extended load result / one-cycle completion pulse
//  addr_exc_o            misaligned or out-of-range access (combinational)
//  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o   request channel
//  bus_gnt_i, bus_rvalid_i, bus_rdata_i                      responder side
// -----------------------------------------------------------------------------
module m_mem_initiator
  import mem_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [2:0]  dm_sel_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] pc_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        addr_exc_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  mem_state_e  state_q, state_d;
  logic        latch_s;
  logic        rd_load_s;

  logic        we_q;
  logic [31:0] bus_addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [2:0]  sel_q;
  logic [1:0]  lo_q;
  logic [31:0] rdata_q;

  logic [3:0]  fmt_be_s;
  logic [31:0] fmt_wdata_s;
  logic [31:0] fmt_rdata_s;

  m_mem_lane_fmt u_fmt (
    .wr_sel_i (dm_sel_i),
    .wr_lo_i  (addr_i[1:0]),
    .wdata_i  (wdata_i),
    .be_o     (fmt_be_s),
    .wdata_o  (fmt_wdata_s),
    .rd_sel_i (sel_q),
    .rd_lo_i  (lo_q),
    .rdata_i  (bus_rdata_i),
    .rdata_o  (fmt_rdata_s)
  );

  assign addr_exc_o = req_valid_i &&
                      (sel_misaligned(dm_sel_i, addr_i[1:0]) || (addr_i >= ADDR_LIMIT));
  // DONE releases the pipeline so the next op can be presented in IDLE.
  assign stall_o       = req_valid_i && !addr_exc_o && (state_q != ST_DONE);
  assign bus_req_o     = (state_q == ST_REQ);
  assign rdata_valid_o = (state_q == ST_DONE);
  assign bus_we_o      = we_q;
  assign bus_addr_o    = bus_addr_q;
  assign bus_be_o      = be_q;
  assign bus_wdata_o   = wdata_q;
  assign rdata_o       = rdata_q;

  // Next-state and control decode
  always_comb begin
    state_d   = state_q;
    latch_s   = 1'b0;
    rd_load_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && !addr_exc_o) begin
          latch_s = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus_gnt_i) begin
          state_d = we_q ? ST_DONE : ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus_rvalid_i) begin
          rd_load_s = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, captured request and load result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      bus_addr_q <= 32'h0000_0000;
      be_q       <= 4'b0000;
      wdata_q    <= 32'h0000_0000;
      sel_q      <= DM_W;
      lo_q       <= 2'b00;
      rdata_q    <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      if (latch_s) begin
        we_q       <= req_we_i;
        bus_addr_q <= {addr_i[31:2], 2'b00};
        be_q       <= fmt_be_s;
        wdata_q    <= fmt_wdata_s;
        sel_q      <= dm_sel_i;
        lo_q       <= addr_i[1:0];
      end
      if (rd_load_s) begin
        rdata_q <= fmt_rdata_s;
      end
    end
  end

`ifdef MEM_TRACE_EN
  logic [31:0] pc_q;

  // PC of the captured request, for the store trace
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= 32'h0000_0000;
    end else if (latch_s) begin
      pc_q <= pc_i;
    end
  end

  // Store trace: disabled lanes print as zero
  always_ff @(posedge clk) begin
    if (!reset && (state_q == ST_REQ) && bus_gnt_i && we_q) begin
      $display("%d@%h: *%h <= %h", $time, pc_q, bus_addr_q,
               wdata_q & {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}});
    end
  end
`else
  logic unused_pc_s;
  assign unused_pc_s = ^pc_i;
`endif

endmodule

// File: tb/tb_m_mem_initiator.sv
module tb_m_mem_initiator;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  dm_sel;
  logic [31:0] addr, wdata, pc;
  logic        stall, rdata_valid, addr_exc;
  logic [31:0] rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  bus_exp_t    bq[$];
  logic [31:0] rq[$];
  logic [31:0] last_rd = 32'h0;
  int total = 0, bad = 0, grants = 0, pulses = 0;

  always #5 clk = ~clk;

  m_mem_initiator dut (
    .clk(clk), .reset(reset), .req_valid_i(req_valid), .req_we_i(req_we),
    .dm_sel_i(dm_sel), .addr_i(addr), .wdata_i(wdata), .pc_i(pc),
    .stall_o(stall), .rdata_o(rdata), .rdata_valid_o(rdata_valid), .addr_exc_o(addr_exc),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_be_o(bus_be),
    .bus_wdata_o(bus_wdata), .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid),
    .bus_rdata_i(bus_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant or a completion
  always @(negedge clk) begin
    if (!reset) begin
      if (bus_req && bus_gnt) begin
        grants++;
        if (bq.size() == 0) chk("unexpected_grant", 32'd1, 32'd0);
        else begin
          bus_exp_t e;
          e = bq.pop_front();
          chk("bus_we", {31'd0, bus_we}, {31'd0, e.we});
          chk("bus_addr", bus_addr, e.addr);
          chk("bus_be", {28'd0, bus_be}, {28'd0, e.be});
          chk("bus_wdata", bus_wdata, e.wdata);
        end
      end
      if (rdata_valid) begin
        pulses++;
        if (rq.size() == 0) chk("unexpected_rdata_valid", 32'd1, 32'd0);
        else chk("rdata", rdata, rq.pop_front());
      end
    end
  end

  // gnt_n: grant on the gnt_n-th REQ cycle (0 = grant held high);
  // rv_n: rvalid on the rv_n-th RESP cycle
  task automatic access(input logic we, input logic [2:0] sel, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] raw,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_rd, input int gnt_n, input int rv_n);
    int n_req, n_rsp, stalls, exp_stalls;
    bit done, in_resp, go_resp;
    bus_exp_t e;
    e.we = we; e.addr = {a[31:2], 2'b00}; e.be = exp_be; e.wdata = exp_wd;
    bq.push_back(e);
    if (we) rq.push_back(last_rd);
    else begin
      rq.push_back(exp_rd);
      last_rd = exp_rd;
    end
    req_valid = 1'b1; req_we = we; dm_sel = sel; addr = a; wdata = wd; pc = pc + 32'd4;
    n_req = 0; n_rsp = 0; stalls = 0; done = 0; in_resp = 0; go_resp = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      bus_gnt = (gnt_n == 0); bus_rvalid = 1'b0; bus_rdata = raw;
      if (in_resp) begin
        n_rsp++;
        bus_rvalid = (n_rsp >= rv_n);
      end else if (bus_req) begin
        n_req++;
        if (n_req >= gnt_n) begin
          bus_gnt = 1'b1;
          if (!we) go_resp = 1;
        end
      end
      @(negedge clk);
      if (stall) stalls++;
      if (rdata_valid) done = 1;
      @(posedge clk); #1;
      if (bus_rvalid) in_resp = 0;
      else if (go_resp) in_resp = 1;
      go_resp = 0;
    end
    if (!done) chk("access_timeout", 32'd1, 32'd0);
    exp_stalls = 1 + ((gnt_n < 1) ? 1 : gnt_n) + (we ? 0 : rv_n);
    chk("stall_cycles", stalls, exp_stalls);
    req_valid = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
  endtask

  task automatic exc_check(input logic [2:0] sel, input logic [31:0] a);
    req_valid = 1'b1; req_we = 1'b0; dm_sel = sel; addr = a; wdata = 32'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("addr_exc", {31'd0, addr_exc}, 32'd1);
      chk("exc_stall", {31'd0, stall}, 32'd0);
      chk("exc_bus_req", {31'd0, bus_req}, 32'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g0, p0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; dm_sel = DM_W; addr = 32'h0;
    wdata = 32'h0; pc = 32'h100; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    @(posedge clk); #1;

    // we sel addr wdata raw be bus_wdata rdata gnt_n rv_n
    access(1'b1, DM_W,  32'h10,   32'hDEADBEEF, 32'h0,        4'b1111, 32'hDEADBEEF, 32'h0,        2, 0);
    access(1'b0, DM_B,  32'h13,   32'h0,        32'h80FF0000, 4'b1000, 32'h0,        32'hFFFFFF80, 1, 2);
    access(1'b0, DM_BU, 32'h13,   32'h0,        32'h80FF0000, 4'b1000, 32'h0,        32'h00000080, 3, 1);
    access(1'b1, DM_H,  32'h22,   32'h1234ABCD, 32'h0,        4'b1100, 32'hABCDABCD, 32'h0,        1, 0);
    access(1'b1, DM_B,  32'h41,   32'h000000A5, 32'h0,        4'b0010, 32'hA5A5A5A5, 32'h0,        1, 0);
    access(1'b0, DM_H,  32'h22,   32'h0,        32'h80011234, 4'b1100, 32'h0,        32'hFFFF8001, 1, 1);
    access(1'b0, DM_HU, 32'h20,   32'h0,        32'h8001F234, 4'b0011, 32'h0,        32'h0000F234, 1, 3);
    access(1'b0, DM_W,  32'h0C,   32'h0,        32'h12345678, 4'b1111, 32'h0,        32'h12345678, 2, 1);
    access(1'b0, DM_B,  32'h11,   32'h0,        32'h00007F00, 4'b0010, 32'h0,        32'h0000007F, 1, 1);
    access(1'b0, DM_B,  32'h2FFF, 32'h0,        32'hAA000000, 4'b1000, 32'h0,        32'hFFFFFFAA, 1, 1);
    access(1'b0, 3'd7,  32'h04,   32'h0,        32'h11111111, 4'b1111, 32'h0,        32'h0,        1, 1);

    exc_check(DM_W, 32'h06);
    exc_check(DM_B, 32'h3000);
    exc_check(DM_H, 32'h01);

    // Reset while a load waits in RESP
    access(1'b0, DM_W, 32'h18, 32'h0, 32'h5A5A5A5A, 4'b1111, 32'h0, 32'h5A5A5A5A, 1, 1);
    begin
      bus_exp_t e;
      e.we = 1'b0; e.addr = 32'h08; e.be = 4'b1111; e.wdata = 32'h0;
      bq.push_back(e);
    end
    req_valid = 1'b1; req_we = 1'b0; dm_sel = DM_W; addr = 32'h08; wdata = 32'h0;
    @(posedge clk); #1;
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    @(negedge clk);
    chk("resp_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    last_rd = 32'h0;
    @(negedge clk);
    chk("post_rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("post_rst_stall", {31'd0, stall}, 32'd0);
    chk("post_rst_rdata", rdata, 32'd0);
    chk("post_rst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
    @(posedge clk); #1;
    bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("late_rvalid_pulse", {31'd0, rdata_valid}, 32'd0);
      chk("late_rvalid_rdata", rdata, 32'd0);
      @(posedge clk); #1;
    end
    bus_rvalid = 1'b0;

    // Back-to-back store then load with grant held high
    g0 = grants; p0 = pulses;
    access(1'b1, DM_W, 32'h30, 32'hCAFEF00D, 32'h0,        4'b1111, 32'hCAFEF00D, 32'h0,        0, 0);
    access(1'b0, DM_W, 32'h30, 32'h0,        32'h0BADCAFE, 4'b1111, 32'h0,        32'h0BADCAFE, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_grants", grants - g0, 32'd2);
    chk("b2b_pulses", pulses - p0, 32'd2);
    chk("bus_queue_empty", bq.size(), 32'd0);
    chk("resp_queue_empty", rq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
